// File: rtl/comet_mem_master_if.sv
// Bus bundle between the fetch/data requesters, comet_mem_master and memory.
// master: view of comet_mem_master (drives acks, results and mem_* controls).
// slave : view of the requesters/memory environment.
interface comet_mem_master_if;
    localparam int unsigned W = 16;

    // Instruction fetch channel
    logic         fetch_req;
    logic [W-1:0] fetch_pc;
    logic         fetch_ack;
    logic [W-1:0] ir_op;
    logic [W-1:0] ir_adr;
    logic         ir_len2;

    // Data load/store channel
    logic         dreq;
    logic         dwe;
    logic [W-1:0] daddr;
    logic [W-1:0] dwdata;
    logic         dack;
    logic [W-1:0] drdata;

    // Memory port (combinational read, write committed on falling edge)
    logic         mem_we;
    logic [W-1:0] mem_waddr;
    logic [W-1:0] mem_wdata;
    logic         mem_re;
    logic [W-1:0] mem_raddr;
    logic [W-1:0] mem_rdata;

    logic         busy;

    modport master (
        input  fetch_req, fetch_pc, dreq, dwe, daddr, dwdata, mem_rdata,
        output fetch_ack, ir_op, ir_adr, ir_len2, dack, drdata,
               mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr, busy
    );

    modport slave (
        output fetch_req, fetch_pc, dreq, dwe, daddr, dwdata, mem_rdata,
        input  fetch_ack, ir_op, ir_adr, ir_len2, dack, drdata,
               mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr, busy
    );
endinterface

// File: rtl/comet_mem_master.sv
// Single-port memory master arbitrating instruction fetches (1 or 2 words)
// and data loads/stores; one transaction in flight, data has priority.
// Ports: mclk (rising-edge clock), rst_n (async active-low reset),
//        bus (comet_mem_master_if.master: fetch, data and memory signals).
// Every bus output is a register; mem_* values are computed from the
// next state so the memory sees them during the state they belong to.
module comet_mem_master (
    input  logic                 mclk,
    input  logic                 rst_n,
    comet_mem_master_if.master   bus
);
    localparam int unsigned W = 16;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] F_OP  = 3'd1;
    localparam logic [2:0] F_ADR = 3'd2;
    localparam logic [2:0] ACK_F = 3'd3;
    localparam logic [2:0] D_RD  = 3'd4;
    localparam logic [2:0] D_WR  = 3'd5;
    localparam logic [2:0] ACK_D = 3'd6;

    logic [2:0]   state, state_nxt;
    logic [W-1:0] pc_q, pc_nxt;

    logic         fetch_ack_nxt, dack_nxt, busy_nxt;
    logic         mem_re_nxt, mem_we_nxt;
    logic [W-1:0] mem_raddr_nxt, mem_waddr_nxt, mem_wdata_nxt;
    logic [W-1:0] ir_op_nxt, ir_adr_nxt, drdata_nxt;
    logic         ir_len2_nxt;

    // Opcode byte decode: true when the instruction has no address word
    function automatic logic is_one_word(input logic [7:0] op);
        return (op == 8'h00) || (op == 8'h71) || (op == 8'h81) ||
               (op[2] && (op[7:4] != 4'h6));
    endfunction

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc_q;
        fetch_ack_nxt = 1'b0;
        dack_nxt      = 1'b0;
        mem_re_nxt    = 1'b0;
        mem_we_nxt    = 1'b0;
        mem_raddr_nxt = bus.mem_raddr;
        mem_waddr_nxt = bus.mem_waddr;
        mem_wdata_nxt = bus.mem_wdata;
        ir_op_nxt     = bus.ir_op;
        ir_adr_nxt    = bus.ir_adr;
        ir_len2_nxt   = bus.ir_len2;
        drdata_nxt    = bus.drdata;

        case (state)
            IDLE: begin
                if (bus.dreq) begin
                    if (bus.dwe) begin
                        state_nxt     = D_WR;
                        mem_we_nxt    = 1'b1;
                        mem_waddr_nxt = bus.daddr;
                        mem_wdata_nxt = bus.dwdata;
                    end else begin
                        state_nxt     = D_RD;
                        mem_re_nxt    = 1'b1;
                        mem_raddr_nxt = bus.daddr;
                    end
                end else if (bus.fetch_req) begin
                    state_nxt     = F_OP;
                    pc_nxt        = bus.fetch_pc;
                    mem_re_nxt    = 1'b1;
                    mem_raddr_nxt = bus.fetch_pc;
                end
            end
            F_OP: begin
                ir_op_nxt = bus.mem_rdata;
                if (is_one_word(bus.mem_rdata[15:8])) begin
                    state_nxt     = ACK_F;
                    ir_adr_nxt    = '0;
                    ir_len2_nxt   = 1'b0;
                    fetch_ack_nxt = 1'b1;
                end else begin
                    state_nxt     = F_ADR;
                    mem_re_nxt    = 1'b1;
                    mem_raddr_nxt = pc_q + W'(1);
                end
            end
            F_ADR: begin
                state_nxt     = ACK_F;
                ir_adr_nxt    = bus.mem_rdata;
                ir_len2_nxt   = 1'b1;
                fetch_ack_nxt = 1'b1;
            end
            D_RD: begin
                state_nxt  = ACK_D;
                drdata_nxt = bus.mem_rdata;
                dack_nxt   = 1'b1;
            end
            D_WR: begin
                state_nxt = ACK_D;
                dack_nxt  = 1'b1;
            end
            ACK_F, ACK_D: state_nxt = IDLE;
            default:      state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pc_q          <= '0;
            bus.fetch_ack <= 1'b0;
            bus.dack      <= 1'b0;
            bus.busy      <= 1'b0;
            bus.mem_re    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_raddr <= '0;
            bus.mem_waddr <= '0;
            bus.mem_wdata <= '0;
            bus.ir_op     <= '0;
            bus.ir_adr    <= '0;
            bus.ir_len2   <= 1'b0;
            bus.drdata    <= '0;
        end else begin
            state         <= state_nxt;
            pc_q          <= pc_nxt;
            bus.fetch_ack <= fetch_ack_nxt;
            bus.dack      <= dack_nxt;
            bus.busy      <= busy_nxt;
            bus.mem_re    <= mem_re_nxt;
            bus.mem_we    <= mem_we_nxt;
            bus.mem_raddr <= mem_raddr_nxt;
            bus.mem_waddr <= mem_waddr_nxt;
            bus.mem_wdata <= mem_wdata_nxt;
            bus.ir_op     <= ir_op_nxt;
            bus.ir_adr    <= ir_adr_nxt;
            bus.ir_len2   <= ir_len2_nxt;
            bus.drdata    <= drdata_nxt;
        end
    end
endmodule
